// File: rtl/icb_arb2.sv
// Two-master to one-slave ICB arbiter, one transaction outstanding, local
// response timeout. Define ICB_ARB_RR_EN for round-robin; default is fixed priority (master 0).
module icb_arb2 #(
  parameter int unsigned RSP_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  // master 0
  input  logic        m0_icb_cmd_valid,
  output logic        m0_icb_cmd_ready,
  input  logic        m0_icb_cmd_read,
  input  logic [31:0] m0_icb_cmd_addr,
  input  logic [31:0] m0_icb_cmd_wdata,
  input  logic [3:0]  m0_icb_cmd_wmask,
  output logic        m0_icb_rsp_valid,
  input  logic        m0_icb_rsp_ready,
  output logic [31:0] m0_icb_rsp_rdata,
  output logic        m0_icb_rsp_err,
  // master 1
  input  logic        m1_icb_cmd_valid,
  output logic        m1_icb_cmd_ready,
  input  logic        m1_icb_cmd_read,
  input  logic [31:0] m1_icb_cmd_addr,
  input  logic [31:0] m1_icb_cmd_wdata,
  input  logic [3:0]  m1_icb_cmd_wmask,
  output logic        m1_icb_rsp_valid,
  input  logic        m1_icb_rsp_ready,
  output logic [31:0] m1_icb_rsp_rdata,
  output logic        m1_icb_rsp_err,
  // shared slave
  output logic        s_icb_cmd_valid,
  input  logic        s_icb_cmd_ready,
  output logic        s_icb_cmd_read,
  output logic [31:0] s_icb_cmd_addr,
  output logic [31:0] s_icb_cmd_wdata,
  output logic [3:0]  s_icb_cmd_wmask,
  input  logic        s_icb_rsp_valid,
  output logic        s_icb_rsp_ready,
  input  logic [31:0] s_icb_rsp_rdata,
  input  logic        s_icb_rsp_err
);

  localparam int TW = (RSP_TIMEOUT > 1) ? $clog2(RSP_TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, CMD, RSP, TERR} state_e;

  state_e          state_q, state_d;
  logic            gnt_q, gnt_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic            prio;
  logic            sel_cmd_valid;
  logic            sel_rsp_ready;
  logic            timeout_hit;

  assign sel_cmd_valid = gnt_q ? m1_icb_cmd_valid : m0_icb_cmd_valid;
  assign sel_rsp_ready = gnt_q ? m1_icb_rsp_ready : m0_icb_rsp_ready;

  generate
    if (RSP_TIMEOUT != 0) begin : g_tmo
      assign timeout_hit = (tcnt_q == TW'(RSP_TIMEOUT - 1));
    end else begin : g_no_tmo
      assign timeout_hit = 1'b0;
    end
  endgenerate

`ifdef ICB_ARB_RR_EN
  logic prio_q, prio_d;

  // Priority flips away from the last winner only when a transaction completes.
  always_comb begin
    prio_d = prio_q;
    if ((state_q == RSP && s_icb_rsp_valid && sel_rsp_ready) ||
        (state_q == TERR && sel_rsp_ready))
      prio_d = ~gnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) prio_q <= 1'b0;
    else     prio_q <= prio_d;
  end

  assign prio = prio_q;
`else
  assign prio = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      tcnt_q  <= tcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    tcnt_d  = tcnt_q;
    case (state_q)
      IDLE: begin
        if (m0_icb_cmd_valid || m1_icb_cmd_valid) begin
          gnt_d   = (m0_icb_cmd_valid && m1_icb_cmd_valid) ? prio : m1_icb_cmd_valid;
          state_d = CMD;
        end
      end
      CMD: begin
        if (!sel_cmd_valid) begin
          state_d = IDLE;
        end else if (s_icb_cmd_ready) begin
          state_d = RSP;
          tcnt_d  = '0;
        end
      end
      RSP: begin
        // A pending response freezes the counter so backpressure never times out.
        if (s_icb_rsp_valid) begin
          if (sel_rsp_ready) state_d = IDLE;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
          if (timeout_hit) state_d = TERR;
        end
      end
      TERR: begin
        if (sel_rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    m0_icb_cmd_ready = 1'b0;
    m1_icb_cmd_ready = 1'b0;
    m0_icb_rsp_valid = 1'b0;
    m1_icb_rsp_valid = 1'b0;
    m0_icb_rsp_rdata = 32'h0;
    m1_icb_rsp_rdata = 32'h0;
    m0_icb_rsp_err   = 1'b0;
    m1_icb_rsp_err   = 1'b0;
    s_icb_cmd_valid  = 1'b0;
    s_icb_cmd_read   = 1'b0;
    s_icb_cmd_addr   = 32'h0;
    s_icb_cmd_wdata  = 32'h0;
    s_icb_cmd_wmask  = 4'h0;
    s_icb_rsp_ready  = 1'b0;
    case (state_q)
      IDLE: s_icb_rsp_ready = 1'b1;
      CMD: begin
        s_icb_cmd_valid  = sel_cmd_valid;
        s_icb_cmd_read   = gnt_q ? m1_icb_cmd_read  : m0_icb_cmd_read;
        s_icb_cmd_addr   = gnt_q ? m1_icb_cmd_addr  : m0_icb_cmd_addr;
        s_icb_cmd_wdata  = gnt_q ? m1_icb_cmd_wdata : m0_icb_cmd_wdata;
        s_icb_cmd_wmask  = gnt_q ? m1_icb_cmd_wmask : m0_icb_cmd_wmask;
        m0_icb_cmd_ready = !gnt_q && s_icb_cmd_ready;
        m1_icb_cmd_ready =  gnt_q && s_icb_cmd_ready;
        s_icb_rsp_ready  = 1'b1;
      end
      RSP: begin
        if (gnt_q) begin
          m1_icb_rsp_valid = s_icb_rsp_valid;
          m1_icb_rsp_rdata = s_icb_rsp_rdata;
          m1_icb_rsp_err   = s_icb_rsp_err;
        end else begin
          m0_icb_rsp_valid = s_icb_rsp_valid;
          m0_icb_rsp_rdata = s_icb_rsp_rdata;
          m0_icb_rsp_err   = s_icb_rsp_err;
        end
        s_icb_rsp_ready = sel_rsp_ready;
      end
      TERR: begin
        m0_icb_rsp_valid = !gnt_q;
        m0_icb_rsp_err   = !gnt_q;
        m1_icb_rsp_valid =  gnt_q;
        m1_icb_rsp_err   =  gnt_q;
        s_icb_rsp_ready  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_icb_arb2.sv
// Directed bench for icb_arb2: reset, single write, arbitration order,
// response timeout, response backpressure, command abort and reset mid-transaction.
module tb_icb_arb2;
  logic        clk = 1'b0;
  logic        rst;
  logic        m0_icb_cmd_valid, m0_icb_cmd_ready, m0_icb_cmd_read;
  logic [31:0] m0_icb_cmd_addr, m0_icb_cmd_wdata;
  logic [3:0]  m0_icb_cmd_wmask;
  logic        m0_icb_rsp_valid, m0_icb_rsp_ready, m0_icb_rsp_err;
  logic [31:0] m0_icb_rsp_rdata;
  logic        m1_icb_cmd_valid, m1_icb_cmd_ready, m1_icb_cmd_read;
  logic [31:0] m1_icb_cmd_addr, m1_icb_cmd_wdata;
  logic [3:0]  m1_icb_cmd_wmask;
  logic        m1_icb_rsp_valid, m1_icb_rsp_ready, m1_icb_rsp_err;
  logic [31:0] m1_icb_rsp_rdata;
  logic        s_icb_cmd_valid, s_icb_cmd_ready, s_icb_cmd_read;
  logic [31:0] s_icb_cmd_addr, s_icb_cmd_wdata;
  logic [3:0]  s_icb_cmd_wmask;
  logic        s_icb_rsp_valid, s_icb_rsp_ready, s_icb_rsp_err;
  logic [31:0] s_icb_rsp_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  icb_arb2 #(.RSP_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .m0_icb_cmd_valid(m0_icb_cmd_valid), .m0_icb_cmd_ready(m0_icb_cmd_ready),
    .m0_icb_cmd_read(m0_icb_cmd_read), .m0_icb_cmd_addr(m0_icb_cmd_addr),
    .m0_icb_cmd_wdata(m0_icb_cmd_wdata), .m0_icb_cmd_wmask(m0_icb_cmd_wmask),
    .m0_icb_rsp_valid(m0_icb_rsp_valid), .m0_icb_rsp_ready(m0_icb_rsp_ready),
    .m0_icb_rsp_rdata(m0_icb_rsp_rdata), .m0_icb_rsp_err(m0_icb_rsp_err),
    .m1_icb_cmd_valid(m1_icb_cmd_valid), .m1_icb_cmd_ready(m1_icb_cmd_ready),
    .m1_icb_cmd_read(m1_icb_cmd_read), .m1_icb_cmd_addr(m1_icb_cmd_addr),
    .m1_icb_cmd_wdata(m1_icb_cmd_wdata), .m1_icb_cmd_wmask(m1_icb_cmd_wmask),
    .m1_icb_rsp_valid(m1_icb_rsp_valid), .m1_icb_rsp_ready(m1_icb_rsp_ready),
    .m1_icb_rsp_rdata(m1_icb_rsp_rdata), .m1_icb_rsp_err(m1_icb_rsp_err),
    .s_icb_cmd_valid(s_icb_cmd_valid), .s_icb_cmd_ready(s_icb_cmd_ready),
    .s_icb_cmd_read(s_icb_cmd_read), .s_icb_cmd_addr(s_icb_cmd_addr),
    .s_icb_cmd_wdata(s_icb_cmd_wdata), .s_icb_cmd_wmask(s_icb_cmd_wmask),
    .s_icb_rsp_valid(s_icb_rsp_valid), .s_icb_rsp_ready(s_icb_rsp_ready),
    .s_icb_rsp_rdata(s_icb_rsp_rdata), .s_icb_rsp_err(s_icb_rsp_err)
  );

  task automatic drive_idle();
    m0_icb_cmd_valid = 0; m0_icb_cmd_read = 0; m0_icb_cmd_addr = 0;
    m0_icb_cmd_wdata = 0; m0_icb_cmd_wmask = 0; m0_icb_rsp_ready = 0;
    m1_icb_cmd_valid = 0; m1_icb_cmd_read = 0; m1_icb_cmd_addr = 0;
    m1_icb_cmd_wdata = 0; m1_icb_cmd_wmask = 0; m1_icb_rsp_ready = 0;
    s_icb_cmd_ready = 0; s_icb_rsp_valid = 0; s_icb_rsp_rdata = 0; s_icb_rsp_err = 0;
  endtask

  task automatic test_reset();
    rst = 1; drive_idle();
    repeat (2) @(negedge clk);
    rst = 0; #1;
    checks++; if (s_icb_rsp_ready !== 1'b1) begin errors++; $display("FAIL reset_s_rsp_ready got %b want 1", s_icb_rsp_ready); end
    checks++; if (s_icb_cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_s_cmd_valid got %b want 0", s_icb_cmd_valid); end
    checks++; if ({m0_icb_cmd_ready, m1_icb_cmd_ready, m0_icb_rsp_valid, m1_icb_rsp_valid} !== 4'b0)
      begin errors++; $display("FAIL reset_master_outs got %b want 0000", {m0_icb_cmd_ready, m1_icb_cmd_ready, m0_icb_rsp_valid, m1_icb_rsp_valid}); end
  endtask

  task automatic test_single_write();
    @(negedge clk);
    m0_icb_cmd_valid = 1; m0_icb_cmd_read = 0; m0_icb_cmd_addr = 32'h0;
    m0_icb_cmd_wdata = 32'h12345678; m0_icb_cmd_wmask = 4'hF; s_icb_cmd_ready = 1;
    #1;
    checks++; if (m0_icb_cmd_ready !== 1'b0) begin errors++; $display("FAIL wr_ready_arb_cycle got %b want 0", m0_icb_cmd_ready); end
    @(negedge clk); #1;
    checks++; if (m0_icb_cmd_ready !== 1'b1) begin errors++; $display("FAIL wr_ready_cmd got %b want 1", m0_icb_cmd_ready); end
    checks++; if ({s_icb_cmd_valid, s_icb_cmd_read, s_icb_cmd_wmask} !== 6'b10_1111)
      begin errors++; $display("FAIL wr_fwd_ctrl got %b want 101111", {s_icb_cmd_valid, s_icb_cmd_read, s_icb_cmd_wmask}); end
    checks++; if (s_icb_cmd_wdata !== 32'h12345678 || s_icb_cmd_addr !== 32'h0)
      begin errors++; $display("FAIL wr_fwd_data got %h/%h want 00000000/12345678", s_icb_cmd_addr, s_icb_cmd_wdata); end
    checks++; if (m1_icb_cmd_ready !== 1'b0) begin errors++; $display("FAIL wr_m1_ready got %b want 0", m1_icb_cmd_ready); end
    @(negedge clk);
    m0_icb_cmd_valid = 0; s_icb_cmd_ready = 0; #1;
    checks++; if (m0_icb_rsp_valid !== 1'b0 || s_icb_cmd_valid !== 1'b0)
      begin errors++; $display("FAIL wr_rsp_wait1 got %b%b want 00", m0_icb_rsp_valid, s_icb_cmd_valid); end
    @(negedge clk);
    s_icb_rsp_valid = 1; s_icb_rsp_rdata = 32'h0; s_icb_rsp_err = 0; m0_icb_rsp_ready = 1; #1;
    checks++; if (m0_icb_rsp_valid !== 1'b1 || m0_icb_rsp_err !== 1'b0)
      begin errors++; $display("FAIL wr_rsp got valid=%b err=%b want 1/0", m0_icb_rsp_valid, m0_icb_rsp_err); end
    checks++; if (m1_icb_rsp_valid !== 1'b0 || m1_icb_cmd_ready !== 1'b0 || s_icb_rsp_ready !== 1'b1)
      begin errors++; $display("FAIL wr_rsp_side got m1v=%b m1r=%b srr=%b want 0/0/1", m1_icb_rsp_valid, m1_icb_cmd_ready, s_icb_rsp_ready); end
    $display("txn single_write m0 addr=%h wdata=%h err=%b", 32'h0, 32'h12345678, m0_icb_rsp_err);
    @(negedge clk);
    s_icb_rsp_valid = 0; m0_icb_rsp_ready = 0; #1;
    checks++; if (m0_icb_rsp_valid !== 1'b0 || s_icb_rsp_ready !== 1'b1)
      begin errors++; $display("FAIL wr_back_idle got v=%b srr=%b want 0/1", m0_icb_rsp_valid, s_icb_rsp_ready); end
  endtask

  task automatic test_back_to_back();
    int exp_m;
    int got_m;
    bit found;
    rst = 1; drive_idle();
    @(negedge clk); rst = 0;
    m0_icb_cmd_valid = 1; m0_icb_cmd_read = 1; m0_icb_cmd_addr = 32'h10;
    m1_icb_cmd_valid = 1; m1_icb_cmd_read = 1; m1_icb_cmd_addr = 32'h20;
    m0_icb_rsp_ready = 1; m1_icb_rsp_ready = 1; s_icb_cmd_ready = 1;
    for (int i = 0; i < 4; i++) begin
`ifdef ICB_ARB_RR_EN
      exp_m = i % 2;
`else
      exp_m = 0;
`endif
      found = 0;
      for (int k = 0; k < 8 && !found; k++) begin
        @(negedge clk); #1;
        if (s_icb_cmd_valid) found = 1;
      end
      checks++; if (!found) begin errors++; $display("FAIL b2b_cmd_timeout txn %0d got no cmd want cmd", i); end
      got_m = m1_icb_cmd_ready ? 1 : 0;
      checks++; if (got_m !== exp_m || (m0_icb_cmd_ready & m1_icb_cmd_ready))
        begin errors++; $display("FAIL b2b_grant txn %0d got m%0d want m%0d", i, got_m, exp_m); end
      checks++; if (s_icb_cmd_addr !== ((exp_m == 1) ? 32'h20 : 32'h10))
        begin errors++; $display("FAIL b2b_addr txn %0d got %h want m%0d addr", i, s_icb_cmd_addr, exp_m); end
      @(negedge clk);
      s_icb_rsp_valid = 1; s_icb_rsp_rdata = 32'hA0 + i; #1;
      checks++;
      if (exp_m == 1) begin
        if (m1_icb_rsp_valid !== 1'b1 || m0_icb_rsp_valid !== 1'b0 || m1_icb_rsp_rdata !== 32'hA0 + i)
          begin errors++; $display("FAIL b2b_rsp txn %0d got m0v=%b m1v=%b rdata=%h", i, m0_icb_rsp_valid, m1_icb_rsp_valid, m1_icb_rsp_rdata); end
      end else begin
        if (m0_icb_rsp_valid !== 1'b1 || m1_icb_rsp_valid !== 1'b0 || m0_icb_rsp_rdata !== 32'hA0 + i)
          begin errors++; $display("FAIL b2b_rsp txn %0d got m0v=%b m1v=%b rdata=%h", i, m0_icb_rsp_valid, m1_icb_rsp_valid, m0_icb_rsp_rdata); end
      end
      $display("txn b2b %0d granted m%0d rdata=%h", i, got_m, 32'hA0 + i);
      @(negedge clk);
      s_icb_rsp_valid = 0;
      if (i == 3) begin m0_icb_cmd_valid = 0; m1_icb_cmd_valid = 0; end
    end
    drive_idle();
  endtask

  task automatic test_timeout();
    int early;
    @(negedge clk);
    m1_icb_cmd_valid = 1; m1_icb_cmd_read = 1; m1_icb_cmd_addr = 32'h40; s_icb_cmd_ready = 1;
    s_icb_rsp_rdata = 32'hDEADBEEF; s_icb_rsp_err = 0;
    @(negedge clk); #1;
    checks++; if (m1_icb_cmd_ready !== 1'b1 || m0_icb_cmd_ready !== 1'b0)
      begin errors++; $display("FAIL tmo_grant_m1 got m0r=%b m1r=%b want 0/1", m0_icb_cmd_ready, m1_icb_cmd_ready); end
    @(negedge clk);
    m1_icb_cmd_valid = 0; s_icb_cmd_ready = 0;
    early = 0;
    for (int k = 0; k < 16; k++) begin
      #1; if (m1_icb_rsp_valid !== 1'b0) early++;
      @(negedge clk);
    end
    #1;
    checks++; if (early != 0) begin errors++; $display("FAIL tmo_early got %0d valid cycles want 0", early); end
    checks++; if (m1_icb_rsp_valid !== 1'b1 || m1_icb_rsp_err !== 1'b1 || m1_icb_rsp_rdata !== 32'h0)
      begin errors++; $display("FAIL tmo_err_rsp got v=%b err=%b rdata=%h want 1/1/0", m1_icb_rsp_valid, m1_icb_rsp_err, m1_icb_rsp_rdata); end
    checks++; if (m0_icb_rsp_valid !== 1'b0) begin errors++; $display("FAIL tmo_m0_quiet got %b want 0", m0_icb_rsp_valid); end
    @(negedge clk);
    s_icb_rsp_valid = 1; #1;
    checks++; if (m1_icb_rsp_rdata !== 32'h0 || m1_icb_rsp_err !== 1'b1 || s_icb_rsp_ready !== 1'b1)
      begin errors++; $display("FAIL tmo_late_drop got rdata=%h err=%b srr=%b want 0/1/1", m1_icb_rsp_rdata, m1_icb_rsp_err, s_icb_rsp_ready); end
    $display("txn timeout m1 addr=%h err=%b", 32'h40, m1_icb_rsp_err);
    @(negedge clk);
    m1_icb_rsp_ready = 1;
    @(negedge clk);
    m1_icb_rsp_ready = 0; #1;
    checks++; if (m1_icb_rsp_valid !== 1'b0 || s_icb_rsp_ready !== 1'b1)
      begin errors++; $display("FAIL tmo_idle_absorb got v=%b srr=%b want 0/1", m1_icb_rsp_valid, s_icb_rsp_ready); end
    @(negedge clk);
    drive_idle();
  endtask

  task automatic test_backpressure();
    int bad;
    @(negedge clk);
    m1_icb_cmd_valid = 1; m1_icb_cmd_read = 1; m1_icb_cmd_addr = 32'h80; s_icb_cmd_ready = 1;
    @(negedge clk);
    @(negedge clk);
    m1_icb_cmd_valid = 0; s_icb_cmd_ready = 0;
    s_icb_rsp_valid = 1; s_icb_rsp_rdata = 32'hCAFE0001; s_icb_rsp_err = 0;
    bad = 0;
    for (int k = 0; k < 30; k++) begin
      #1;
      if (m1_icb_rsp_valid !== 1'b1 || m1_icb_rsp_rdata !== 32'hCAFE0001 ||
          m1_icb_rsp_err !== 1'b0 || s_icb_rsp_ready !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL bp_hold got %0d bad cycles want 0", bad); end
    m1_icb_rsp_ready = 1; #1;
    checks++; if (m1_icb_rsp_valid !== 1'b1 || m1_icb_rsp_rdata !== 32'hCAFE0001 || s_icb_rsp_ready !== 1'b1)
      begin errors++; $display("FAIL bp_deliver got v=%b rdata=%h srr=%b want 1/cafe0001/1", m1_icb_rsp_valid, m1_icb_rsp_rdata, s_icb_rsp_ready); end
    $display("txn backpressure m1 rdata=%h", m1_icb_rsp_rdata);
    @(negedge clk);
    drive_idle(); #1;
    checks++; if (m1_icb_rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_done got %b want 0", m1_icb_rsp_valid); end
  endtask

  task automatic test_cmd_abort();
    @(negedge clk);
    m0_icb_cmd_valid = 1; m0_icb_cmd_addr = 32'hC0;
    @(negedge clk); #1;
    checks++; if (s_icb_cmd_valid !== 1'b1 || m0_icb_cmd_ready !== 1'b0)
      begin errors++; $display("FAIL abort_cmd got sv=%b m0r=%b want 1/0", s_icb_cmd_valid, m0_icb_cmd_ready); end
    @(negedge clk);
    m0_icb_cmd_valid = 0; #1;
    checks++; if (s_icb_cmd_valid !== 1'b0) begin errors++; $display("FAIL abort_drop got %b want 0", s_icb_cmd_valid); end
    @(negedge clk);
    m1_icb_cmd_valid = 1; m1_icb_cmd_addr = 32'hC4; s_icb_cmd_ready = 1;
    @(negedge clk); #1;
    checks++; if (m1_icb_cmd_ready !== 1'b1 || s_icb_cmd_addr !== 32'hC4)
      begin errors++; $display("FAIL abort_regrant got m1r=%b addr=%h want 1/c4", m1_icb_cmd_ready, s_icb_cmd_addr); end
    @(negedge clk);
    m1_icb_cmd_valid = 0; s_icb_cmd_ready = 0; s_icb_rsp_valid = 1; m1_icb_rsp_ready = 1;
    @(negedge clk);
    drive_idle();
  endtask

  task automatic test_reset_in_rsp();
    @(negedge clk);
    m0_icb_cmd_valid = 1; m0_icb_cmd_addr = 32'h100; s_icb_cmd_ready = 1;
    @(negedge clk);
    @(negedge clk);
    m0_icb_cmd_valid = 0; s_icb_cmd_ready = 0; m0_icb_rsp_ready = 1; rst = 1;
    @(negedge clk);
    rst = 0; s_icb_rsp_valid = 1; s_icb_rsp_rdata = 32'h77; #1;
    checks++; if (m0_icb_rsp_valid !== 1'b0 || s_icb_rsp_ready !== 1'b1 || s_icb_cmd_valid !== 1'b0)
      begin errors++; $display("FAIL rst_rsp_idle got m0v=%b srr=%b sv=%b want 0/1/0", m0_icb_rsp_valid, s_icb_rsp_ready, s_icb_cmd_valid); end
    @(negedge clk);
    s_icb_rsp_valid = 0; m1_icb_cmd_valid = 1; m1_icb_cmd_addr = 32'h104; s_icb_cmd_ready = 1; #1;
    checks++; if (m0_icb_rsp_valid !== 1'b0 || m1_icb_cmd_ready !== 1'b0)
      begin errors++; $display("FAIL rst_rsp_quiet got m0v=%b m1r=%b want 0/0", m0_icb_rsp_valid, m1_icb_cmd_ready); end
    @(negedge clk); #1;
    checks++; if (m1_icb_cmd_ready !== 1'b1 || s_icb_cmd_addr !== 32'h104)
      begin errors++; $display("FAIL rst_rsp_next_grant got m1r=%b addr=%h want 1/104", m1_icb_cmd_ready, s_icb_cmd_addr); end
    @(negedge clk);
    m1_icb_cmd_valid = 0; s_icb_cmd_ready = 0;
    s_icb_rsp_valid = 1; s_icb_rsp_rdata = 32'h55; m1_icb_rsp_ready = 1; #1;
    checks++; if (m1_icb_rsp_valid !== 1'b1 || m1_icb_rsp_rdata !== 32'h55)
      begin errors++; $display("FAIL rst_rsp_next_rsp got v=%b rdata=%h want 1/55", m1_icb_rsp_valid, m1_icb_rsp_rdata); end
    $display("txn after_reset m1 rdata=%h", m1_icb_rsp_rdata);
    @(negedge clk);
    drive_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_write();
    test_back_to_back();
    test_timeout();
    test_backpressure();
    test_cmd_abort();
    test_reset_in_rsp();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
